// File: rtl/tcdm_bank_arb_pkg.sv
// Shared helpers for the TCDM bank arbiter: width derivation and one-hot decode.
// Supports up to MaxPorts requesters.
package tcdm_bank_arb_pkg;

  localparam int unsigned MaxPorts    = 32;
  localparam int unsigned MaxIdxWidth = $clog2(MaxPorts);

  localparam int unsigned PerfCntWidth = 32;

  function automatic int unsigned idx_width(input int unsigned num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  function automatic int unsigned wait_width(input int unsigned starve_limit);
    return (starve_limit > 0) ? $clog2(starve_limit + 1) : 1;
  endfunction

  localparam int unsigned DefNumIn       = 4;
  localparam int unsigned DefStarveLimit = 15;
  localparam int unsigned DefIdxWidth    = idx_width(DefNumIn);
  localparam int unsigned DefWaitWidth   = wait_width(DefStarveLimit);

  // OR-reduction of set-bit positions; exact for zero or one-hot inputs.
  function automatic logic [MaxIdxWidth-1:0] onehot_to_idx(input logic [MaxPorts-1:0] oh);
    logic [MaxIdxWidth-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      if (oh[i]) idx = idx | MaxIdxWidth'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Round-robin priority select: rotate the request vector to start at ptr_i and
// pick the first set bit, returning it as one-hot and as an index.
module rr_prio_select
  import tcdm_bank_arb_pkg::*;
#(
  parameter int unsigned NumIn    = DefNumIn,
  parameter int unsigned IdxWidth = idx_width(NumIn)
) (
  input  logic [NumIn-1:0]    req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumIn-1:0]    gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  logic [2*NumIn-1:0] req_dbl;
  logic [NumIn-1:0]   req_rot;
  logic               found;
  int unsigned        k;

  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[NumIn-1:0];
  assign valid_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      if (req_rot[i] && !found) begin
        found    = 1'b1;
        k        = (32'(ptr_i) + i) % NumIn;
        gnt_o[k] = 1'b1;
        idx_o    = IdxWidth'(k);
      end
    end
  end

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Per-bank TCDM leaf arbiter: round-robin with starvation boost, one-cycle response.
// Define TCDM_BANK_ARB_PERF_EN to add conflict/forced-grant performance counters.
module tcdm_bank_arbiter
  import tcdm_bank_arb_pkg::*;
#(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrMemWidth = 12,
  parameter int unsigned StarveLimit  = 15
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NumIn-1:0]                       req_i,
  input  logic [NumIn-1:0][AddrMemWidth-1:0]     add_i,
  input  logic [NumIn-1:0]                       wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]        wdata_i,
  input  logic [NumIn-1:0][DataWidth/8-1:0]      be_i,
  output logic [NumIn-1:0]                       gnt_o,
  output logic [NumIn-1:0]                       rvld_o,
  output logic [DataWidth-1:0]                   rdata_o,
  output logic                                   cs_o,
  output logic [AddrMemWidth-1:0]                add_o,
  output logic                                   wen_o,
  output logic [DataWidth-1:0]                   wdata_o,
  output logic [DataWidth/8-1:0]                 be_o,
  input  logic [DataWidth-1:0]                   rdata_i
`ifdef TCDM_BANK_ARB_PERF_EN
  ,
  output logic [PerfCntWidth-1:0]                conflict_cnt_o,
  output logic [PerfCntWidth-1:0]                starve_cnt_o
`endif
);

  localparam int unsigned IdxWidth  = idx_width(NumIn);
  localparam int unsigned WaitWidth = wait_width(StarveLimit);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic [NumIn-1:0]    resp_q;

  logic [NumIn-1:0]    rr_gnt;
  logic [IdxWidth-1:0] rr_idx;
  logic                rr_valid;

  logic [NumIn-1:0]    starved;
  logic [NumIn-1:0]    starve_oh;
  logic                any_starved;
  logic [IdxWidth-1:0] starve_idx;

  logic [NumIn-1:0]    gnt;
  logic [IdxWidth-1:0] gnt_idx;

  rr_prio_select #(
    .NumIn   (NumIn),
    .IdxWidth(IdxWidth)
  ) u_rr (
    .req_i  (req_i),
    .ptr_i  (ptr_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .valid_o(rr_valid)
  );

  if (StarveLimit > 0) begin : g_starve
    localparam logic [WaitWidth-1:0] Lim = WaitWidth'(StarveLimit);

    logic [NumIn-1:0][WaitWidth-1:0] wait_q, wait_d;

    always_comb begin
      starved = '0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        starved[i] = req_i[i] && (wait_q[i] == Lim);
      end
    end

    // Count only cycles spent requesting without a grant; any gap restarts the count.
    always_comb begin
      wait_d = wait_q;
      for (int unsigned i = 0; i < NumIn; i++) begin
        if (req_i[i] && !gnt[i]) begin
          if (wait_q[i] != Lim) wait_d[i] = wait_q[i] + WaitWidth'(1);
        end else begin
          wait_d[i] = '0;
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wait_q <= '0;
      end else begin
        wait_q <= wait_d;
      end
    end
  end else begin : g_no_starve
    assign starved = '0;
  end

  // Isolate the lowest set bit: lowest-index starved port wins outright.
  assign starve_oh   = starved & (~starved + NumIn'(1));
  assign any_starved = |starved;
  assign starve_idx  = IdxWidth'(onehot_to_idx(MaxPorts'(starve_oh)));

  assign gnt     = any_starved ? starve_oh  : rr_gnt;
  assign gnt_idx = any_starved ? starve_idx : rr_idx;
  assign gnt_o   = gnt;

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = (gnt_idx == IdxWidth'(NumIn - 1)) ? '0 : gnt_idx + IdxWidth'(1);
    end
  end

  // AND-OR mux from the granted port; all-zero when nothing is granted.
  always_comb begin
    add_o   = '0;
    wdata_o = '0;
    be_o    = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      add_o   = add_o   | (add_i[i]   & {AddrMemWidth{gnt[i]}});
      wdata_o = wdata_o | (wdata_i[i] & {DataWidth{gnt[i]}});
      be_o    = be_o    | (be_i[i]    & {(DataWidth/8){gnt[i]}});
    end
  end

  assign wen_o   = |(wen_i & gnt);
  assign cs_o    = rr_valid;
  assign rvld_o  = resp_q;
  assign rdata_o = rdata_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      resp_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      resp_q <= gnt;
    end
  end

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [PerfCntWidth-1:0] conflict_q, starve_q;
  logic                    multi_req;

  // Nonzero iff at least two bits of req_i are set.
  assign multi_req = |(req_i & (req_i - NumIn'(1)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_q <= '0;
      starve_q   <= '0;
    end else begin
      if (multi_req && (conflict_q != '1)) conflict_q <= conflict_q + PerfCntWidth'(1);
      if (any_starved && (starve_q != '1)) starve_q <= starve_q + PerfCntWidth'(1);
    end
  end

  assign conflict_cnt_o = conflict_q;
  assign starve_cnt_o   = starve_q;
`endif

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// Directed bench for tcdm_bank_arbiter with a response scoreboard and a bank memory model.
module tb_tcdm_bank_arbiter;

  typedef struct {
    logic [3:0]  port;
    bit          chk;
    logic [31:0] data;
  } resp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  resp_t       sb[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]         req;
  logic [3:0][11:0]   add;
  logic [3:0]         wen;
  logic [3:0][31:0]   wdata;
  logic [3:0][3:0]    be;
  logic [3:0]         gnt, rvld;
  logic [31:0]        rdata, wdata_b, mem_rd;
  logic               cs, wen_b;
  logic [11:0]        add_b;
  logic [3:0]         be_b;

  logic [3:0]         s_req, s_gnt, s_rvld;
  logic [31:0]        s_rdata, s_wdata;
  logic               s_cs, s_wen;
  logic [11:0]        s_add;
  logic [3:0]         s_be;

`ifdef TCDM_BANK_ARB_PERF_EN
  logic [31:0] conf_cnt, stv_cnt, s_conf_cnt, s_stv_cnt;
`endif

  logic [31:0] mem [4096];

  always #5 clk = ~clk;

  tcdm_bank_arbiter #(
    .NumIn(4), .DataWidth(32), .AddrMemWidth(12), .StarveLimit(15)
  ) u_dut (
    .clk_i  (clk),    .rst_i  (rst),
    .req_i  (req),    .add_i  (add),    .wen_i  (wen),
    .wdata_i(wdata),  .be_i   (be),
    .gnt_o  (gnt),    .rvld_o (rvld),   .rdata_o(rdata),
    .cs_o   (cs),     .add_o  (add_b),  .wen_o  (wen_b),
    .wdata_o(wdata_b),.be_o   (be_b),   .rdata_i(mem_rd)
`ifdef TCDM_BANK_ARB_PERF_EN
    , .conflict_cnt_o(conf_cnt), .starve_cnt_o(stv_cnt)
`endif
  );

  tcdm_bank_arbiter #(
    .NumIn(4), .DataWidth(32), .AddrMemWidth(12), .StarveLimit(2)
  ) u_stv (
    .clk_i  (clk),     .rst_i  (rst),
    .req_i  (s_req),   .add_i  ('0),     .wen_i  ('0),
    .wdata_i('0),      .be_i   ('0),
    .gnt_o  (s_gnt),   .rvld_o (s_rvld), .rdata_o(s_rdata),
    .cs_o   (s_cs),    .add_o  (s_add),  .wen_o  (s_wen),
    .wdata_o(s_wdata), .be_o   (s_be),   .rdata_i(32'h0)
`ifdef TCDM_BANK_ARB_PERF_EN
    , .conflict_cnt_o(s_conf_cnt), .starve_cnt_o(s_stv_cnt)
`endif
  );

  // Single-ported bank with one-cycle read latency and byte-enabled writes.
  always @(posedge clk) begin
    if (cs) begin
      if (wen_b) begin
        for (int b = 0; b < 4; b++) begin
          if (be_b[b]) mem[add_b][8*b +: 8] <= wdata_b[8*b +: 8];
        end
      end else begin
        mem_rd <= mem[add_b];
      end
    end
  end

  function automatic logic [31:0] pat(input logic [11:0] a);
    return 32'h5A5A_0000 | {20'h0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic [11:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] b);
    req[p]   = r;
    add[p]   = a;
    wen[p]   = w;
    wdata[p] = d;
    be[p]    = b;
  endtask

  // Called at a negedge with inputs applied: check grant, queue the response,
  // cross the posedge, then pop and check the response.
  task automatic do_cycle(input string tag, input logic [3:0] exp_gnt, input logic [11:0] exp_add,
                          input bit chk, input logic [31:0] exp_data);
    resp_t e;
    #1;
    check({tag, "/gnt"}, 64'(gnt), 64'(exp_gnt));
    check({tag, "/cs"}, 64'(cs), 64'(|req));
    check({tag, "/add"}, 64'(add_b), 64'(exp_add));
    sb.push_back('{exp_gnt, chk, exp_data});
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "/rvld"}, 64'(rvld), 64'(e.port));
    if (e.chk) check({tag, "/rdata"}, 64'(rdata), 64'(e.data));
  endtask

  task automatic stv_cycle(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt);
    s_req = r;
    #1;
    check({tag, "/gnt"}, 64'(s_gnt), 64'(exp_gnt));
    @(negedge clk);
    check({tag, "/rvld"}, 64'(s_rvld), 64'(exp_gnt));
  endtask

  task automatic do_reset();
    req   = '0;
    s_req = '0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  logic [3:0] stv_req [6];
  logic [3:0] stv_gnt [6];

  initial begin
    req   = '0;
    add   = '0;
    wen   = '0;
    wdata = '0;
    be    = '0;
    s_req = '0;
    for (int a = 0; a < 4096; a++) mem[a] = pat(12'(a));
    mem[12'h010] = 32'hDEAD_BEEF;
    mem[12'h005] = 32'hAABB_CCDD;

    // Reset state
    @(negedge clk);
    check("rst/rvld", 64'(rvld), 64'h0);
    check("rst/gnt", 64'(gnt), 64'h0);
    check("rst/cs", 64'(cs), 64'h0);
    check("rst/add", 64'(add_b), 64'h0);
    check("rst/s_rvld", 64'(s_rvld), 64'h0);
    check("rst/s_idle", 64'({s_add, s_wen, s_wdata, s_be}), 64'h0);
    check("rst/s_misc", 64'({s_cs, s_rdata}), 64'h0);
    rst = 1'b0;

    // Single read from port 2
    set_port(2, 1'b1, 12'h010, 1'b0, 32'h0, 4'hF);
    do_cycle("single_rd", 4'b0100, 12'h010, 1'b1, 32'hDEAD_BEEF);
    req = '0;

    // All four requesting from reset: strict rotation, one grant per cycle
    do_reset();
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 12'h100 + 12'(p), 1'b0, 32'h0, 4'hF);
    for (int c = 0; c < 8; c++) begin
      do_cycle("rr", 4'(1 << (c % 4)), 12'h100 + 12'(c % 4), 1'b1, pat(12'h100 + 12'(c % 4)));
    end
    req = '0;

    // Byte-enabled write then read-back on port 1 (ptr is 0 here)
    set_port(1, 1'b1, 12'h005, 1'b1, 32'h1122_3344, 4'b0101);
    #1;
    check("wr/wen", 64'(wen_b), 64'h1);
    check("wr/wdata", 64'(wdata_b), 64'h1122_3344);
    check("wr/be", 64'(be_b), 64'h5);
    do_cycle("wr", 4'b0010, 12'h005, 1'b0, 32'h0);
    wen[1] = 1'b0;
    do_cycle("rd_after_wr", 4'b0010, 12'h005, 1'b1, 32'hAA22_CC44);

    // Idle cycle: outputs zero, pointer holds at 2
    req = '0;
    #1;
    check("idle/mux", 64'({wen_b, wdata_b, be_b}), 64'h0);
    do_cycle("idle", 4'b0000, 12'h000, 1'b0, 32'h0);
    for (int p = 1; p < 4; p++) set_port(p, 1'b1, 12'h200 + 12'(p), 1'b0, 32'h0, 4'hF);
    do_cycle("ptr_hold", 4'b0100, 12'h202, 1'b1, pat(12'h202));

    // Async reset while a response is pending
    req = '0;
    set_port(2, 1'b1, 12'h010, 1'b0, 32'h0, 4'hF);
    do_cycle("pre_rst", 4'b0100, 12'h010, 1'b1, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    check("async_rst/rvld", 64'(rvld), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int p = 0; p < 4; p++) set_port(p, 1'b1, 12'h100 + 12'(p), 1'b0, 32'h0, 4'hF);
    do_cycle("post_rst", 4'b0001, 12'h100, 1'b1, pat(12'h100));
    req = '0;

    // Three-way contention for ten cycles
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 12'h100 + 12'(p), 1'b0, 32'h0, 4'hF);
    for (int c = 0; c < 10; c++) begin
      do_cycle("conflict", 4'(1 << (c % 3)), 12'h100 + 12'(c % 3), 1'b1, pat(12'h100 + 12'(c % 3)));
    end
    req = '0;
`ifdef TCDM_BANK_ARB_PERF_EN
    check("perf/conflict", 64'(conf_cnt), 64'd10);
    check("perf/starve", 64'(stv_cnt), 64'd0);
`endif

    // StarveLimit=2: forced priority overrides the pointer
    do_reset();
    stv_req = '{4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b1010, 4'b0010};
    stv_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
    for (int c = 0; c < 6; c++) stv_cycle("starve", stv_req[c], stv_gnt[c]);
    s_req = '0;
`ifdef TCDM_BANK_ARB_PERF_EN
    check("perf/s_conflict", 64'(s_conf_cnt), 64'd5);
    check("perf/s_starve", 64'(s_stv_cnt), 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
